operand_packer: RTL and testbench

Stream-to-quad operand packer for the 4-operand adder tree. It accepts a serial stream of WIDTH-bit terms on a valid/ready handshake and collects them into groups of four. Each group is presented in parallel on a, b, c and d ports with an output valid/ready handshake. It sits directly upstream of the adder tree in the convolution datapath and is the producer end of that block's operand interface.

---
 rtl/operand_packer.sv | 137 +++++++++++++
 tb/tb_operand_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_packer.sv
// ---------------------------------------------------------------------------
// operand_packer
//
// Packs a serial stream of WIDTH-bit terms into groups of four operands for
// the downstream 4-input adder tree. Terms arrive on a valid/ready handshake.
// Each completed group is presented in parallel on out_a..out_d, with the
// first accepted term on out_a, and is handed off on an output valid/ready
// handshake.
//
// Optional feature (macro PACKER_LAST_PAD_EN):
//   defined   - in_last closes a group early. Unused positions are zero-padded
//               and out_count reports 1..4.
//   undefined - in_last is ignored. Groups close only on the 4th term, and
//               out_count is 4 for every group.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active high
//   in_data    in   [WIDTH-1:0] incoming term
//   in_valid   in   in_data valid
//   in_ready   out  term accepted this cycle when in_valid is also high
//   in_last    in   final term of a group (only used with PACKER_LAST_PAD_EN)
//   out_a..d   out  [WIDTH-1:0] operands in arrival order
//   out_count  out  [2:0] number of real operands in the group (1..4)
//   out_valid  out  output group valid
//   out_ready  in   consumer takes the group this cycle
// ---------------------------------------------------------------------------
module operand_packer #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [2:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] slot0, slot1, slot2;
    logic [1:0]       fill;
    logic             last_close;
    logic             accept;
    logic             closing;
    logic             transfer;
    logic [WIDTH-1:0] nxt_a, nxt_b, nxt_c, nxt_d;

`ifdef PACKER_LAST_PAD_EN
    assign last_close = in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign last_close     = 1'b0;
`endif

    // A closing beat has to write the output register, so it may only go
    // ahead when that register is empty or draining this cycle. Beats that
    // only fill a slot never wait for the output side.
    assign in_ready = ((fill != 2'd3) && !last_close) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign closing  = accept && ((fill == 2'd3) || last_close);
    assign transfer = out_valid && out_ready;

    // Group assembly: buffered slots below fill, the closing term at
    // position fill, and zeros above it.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        nxt_c = '0;
        nxt_d = '0;
        case (fill)
            2'd0: begin
                nxt_a = in_data;
            end
            2'd1: begin
                nxt_a = slot0;
                nxt_b = in_data;
            end
            2'd2: begin
                nxt_a = slot0;
                nxt_b = slot1;
                nxt_c = in_data;
            end
            default: begin
                nxt_a = slot0;
                nxt_b = slot1;
                nxt_c = slot2;
                nxt_d = in_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0     <= '0;
            slot1     <= '0;
            slot2     <= '0;
            fill      <= 2'd0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_count <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            if (closing) begin
                out_a     <= nxt_a;
                out_b     <= nxt_b;
                out_c     <= nxt_c;
                out_d     <= nxt_d;
                out_count <= {1'b0, fill} + 3'd1;
                out_valid <= 1'b1;
                fill      <= 2'd0;
            end else begin
                if (accept) begin
                    case (fill)
                        2'd0:    slot0 <= in_data;
                        2'd1:    slot1 <= in_data;
                        default: slot2 <= in_data;
                    endcase
                    fill <= fill + 2'd1;
                end
                // Operand values keep their last contents after a hand-off.
                if (transfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_packer.sv
module tb_operand_packer;

    localparam int WIDTH = 13;
`ifdef PACKER_LAST_PAD_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic [2:0]       out_count;
    logic             out_valid;
    logic             out_ready;

    always #5 clk = ~clk;

    operand_packer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [2:0]       cnt;
    } grp_t;

    grp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               mon_en   = 1'b0;
    int               n_groups = 0;

    // reference model state
    int               m_fill = 0;
    logic [WIDTH-1:0] m_slot [3];
    bit               m_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        return (m_fill < 3 && !(LAST_EN && in_last)) || !m_ov || out_ready;
    endfunction

    // Reference model: advance on every rising edge from the driven inputs.
    always @(posedge clk) begin
        bit acc, cls, xfer;
        logic [WIDTH-1:0] v [4];
        grp_t g;
        if (rst) begin
            m_fill = 0;
            m_ov   = 1'b0;
            exp_q.delete();
        end else begin
            acc  = in_valid && m_rdy();
            cls  = acc && (m_fill == 3 || (LAST_EN && in_last));
            xfer = m_ov && out_ready;
            if (cls) begin
                for (int i = 0; i < 4; i++) v[i] = '0;
                for (int i = 0; i < m_fill; i++) v[i] = m_slot[i];
                v[m_fill] = in_data;
                g.a = v[0]; g.b = v[1]; g.c = v[2]; g.d = v[3];
                g.cnt = 3'(m_fill + 1);
                exp_q.push_back(g);
                m_ov   = 1'b1;
                m_fill = 0;
            end else begin
                if (acc) begin
                    m_slot[m_fill] = in_data;
                    m_fill++;
                end
                if (xfer) m_ov = 1'b0;
            end
        end
    end

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        grp_t g;
        if (mon_en && !rst) begin
            check("in_ready", 32'(in_ready), 32'(m_rdy()));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_group", 32'(out_valid), 32'd0);
                end else begin
                    g = exp_q[0];
                    check("out_a", 32'(out_a), 32'(g.a));
                    check("out_b", 32'(out_b), 32'(g.b));
                    check("out_c", 32'(out_c), 32'(g.c));
                    check("out_d", 32'(out_d), 32'(g.d));
                    check("out_count", 32'(out_count), 32'(g.cnt));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_groups++;
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one term and hold it until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        bit acc;
        int budget;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        acc      = 1'b0;
        budget   = 0;
        while (!acc && budget < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_d", 32'(out_d), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // full group
        for (int i = 1; i <= 4; i++) send(WIDTH'(i), 1'b0);
        idle_cycles(3);

        // stall with out_ready low
        out_ready = 1'b0;
        for (int i = 'h10; i <= 'h16; i++) send(WIDTH'(i), 1'b0);
        in_data  = WIDTH'('h17);
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        idle_cycles(3);
        out_ready = 1'b1;
        idle_cycles(2);

        // early close: macro on -> group of 2, off -> group completes after 2 more
        send(WIDTH'('h1FFF), 1'b0);
        send(WIDTH'(5), 1'b1);
        idle_cycles(2);
        if (!LAST_EN) begin
            check("noclose_no_output", 32'(out_valid), 32'd0);
            send(WIDTH'(6), 1'b0);
            send(WIDTH'(7), 1'b0);
            idle_cycles(2);
        end

        // back-to-back full groups with transfer and load in the same cycle
        for (int i = 0; i < 12; i++) send(WIDTH'('h100 + i), 1'b0);
        idle_cycles(2);

        // back-to-back single-term groups
        for (int i = 0; i < 8; i++) send(WIDTH'('h40 + i), 1'b1);
        idle_cycles(2);

        // reset mid-group
        send(WIDTH'('h55), 1'b0);
        send(WIDTH'('h66), 1'b0);
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 7; i <= 10; i++) send(WIDTH'(i), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_a", 32'(out_a), 32'd7);
        check("midrst_d", 32'(out_d), 32'd10);
        check("midrst_count", 32'(out_count), 32'd4);
        @(posedge clk);
        #1;
        idle_cycles(2);

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end

        // drain
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle_cycles(4);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        if (n_groups < 20) check("groups_seen", 32'(n_groups), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
